// File: rtl/fp_pkg.sv
// Shared widths, FSM state type and normalizer result bundle for the
// floating-point normalize/arbitrate slice.
package fp_pkg;

  localparam int unsigned MANT_IN_W = 25;
  localparam int unsigned FRAC_W    = 23;
  localparam int unsigned EXP_W     = 8;
  localparam int unsigned LZC_W     = 5;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    HOLD
  } state_t;

  typedef struct packed {
    logic [FRAC_W-1:0] frac;
    logic [EXP_W-1:0]  exp;
    logic              zero;
    logic              ovf;
    logic              unf;
  } norm_res_t;

endpackage

// File: rtl/fp_normalizer.sv
// Combinational mantissa normalizer: carry right-shift, zero detect, or
// leading-zero left-shift with modulo-256 exponent adjust.
module fp_normalizer
  import fp_pkg::*;
(
  input  logic [MANT_IN_W-1:0] mant,
  input  logic [EXP_W-1:0]     exp,
  output norm_res_t            res
);

  logic [LZC_W-1:0] shift;
  logic [FRAC_W:0]  shifted;

  always_comb begin
    // Ascending scan: the last hit is the highest set bit below the carry.
    shift = '0;
    for (int unsigned i = 0; i <= FRAC_W; i++) begin
      if (mant[i]) shift = LZC_W'(FRAC_W - i);
    end
    shifted = mant[FRAC_W:0] << shift;

    res = '0;
    if (mant[MANT_IN_W-1]) begin
      res.frac = mant[FRAC_W:1];
      res.exp  = exp + 1'b1;
      res.ovf  = (exp == '1);
    end else if (mant == '0) begin
      res.zero = 1'b1;
    end else begin
      res.frac = shifted[FRAC_W-1:0];
      res.exp  = exp - EXP_W'(shift);
      res.unf  = (EXP_W'(shift) > exp);
    end
  end

endmodule

// File: rtl/fp_norm_arbiter.sv
// Round-robin arbiter sharing one fp_normalizer between N_REQ requesters;
// the result is registered and held until the consumer takes it.
module fp_norm_arbiter
  import fp_pkg::*;
#(
  parameter  int unsigned N_REQ = 2,
  parameter  int unsigned TAG_W = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*MANT_IN_W-1:0] req_mant,
  input  logic [N_REQ*EXP_W-1:0]     req_exp,
  input  logic [N_REQ-1:0]           req_sign,
  input  logic [N_REQ*TAG_W-1:0]     req_tag,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_W-1:0]            res_id,
  output logic [TAG_W-1:0]           res_tag,
  output logic                       res_sign,
  output logic [FRAC_W-1:0]          res_mant,
  output logic [EXP_W-1:0]           res_exp,
  output logic                       res_zero,
  output logic                       res_ovf,
  output logic                       res_unf
);

  state_t state, state_nxt;

  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      grant;
  logic                 any_valid;
  logic                 accept;

  logic [MANT_IN_W-1:0] sel_mant;
  logic [EXP_W-1:0]     sel_exp;
  logic                 sel_sign;
  logic [TAG_W-1:0]     sel_tag;

  logic [MANT_IN_W-1:0] op_mant;
  logic [EXP_W-1:0]     op_exp;
  logic                 op_sign;
  logic [TAG_W-1:0]     op_tag;
  logic [ID_W-1:0]      op_id;

  norm_res_t            norm;

  // Scans ptr+N .. ptr+1 so the requester nearest after ptr overwrites last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    int unsigned     idx;
    pick = ptr;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      idx = (32'(ptr) + k) % N_REQ;
      if (valid[idx]) pick = ID_W'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    grant     = rr_pick(req_valid, rr_ptr);
    any_valid = |req_valid;
    sel_mant  = '0;
    sel_exp   = '0;
    sel_sign  = 1'b0;
    sel_tag   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == grant) begin
        sel_mant = req_mant[i*MANT_IN_W +: MANT_IN_W];
        sel_exp  = req_exp[i*EXP_W +: EXP_W];
        sel_sign = req_sign[i];
        sel_tag  = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          req_ready = N_REQ'(1) << grant;
          accept    = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM:    state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  fp_normalizer u_norm (
    .mant (op_mant),
    .exp  (op_exp),
    .res  (norm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= ID_W'(N_REQ - 1);
      op_mant   <= '0;
      op_exp    <= '0;
      op_sign   <= 1'b0;
      op_tag    <= '0;
      op_id     <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_tag   <= '0;
      res_sign  <= 1'b0;
      res_mant  <= '0;
      res_exp   <= '0;
      res_zero  <= 1'b0;
      res_ovf   <= 1'b0;
      res_unf   <= 1'b0;
    end else begin
      if (accept) begin
        op_mant <= sel_mant;
        op_exp  <= sel_exp;
        op_sign <= sel_sign;
        op_tag  <= sel_tag;
        op_id   <= grant;
        rr_ptr  <= grant;
      end
      if (state == NORM) begin
        res_valid <= 1'b1;
        res_id    <= op_id;
        res_tag   <= op_tag;
        res_sign  <= op_sign;
        res_mant  <= norm.frac;
        res_exp   <= norm.exp;
        res_zero  <= norm.zero;
        res_ovf   <= norm.ovf;
        res_unf   <= norm.unf;
      end
      if (state == HOLD && res_ready) res_valid <= 1'b0;
    end
  end

endmodule
